// File: rtl/decoder_pkg.sv
// Shared state and mode encodings for the scanning one-hot decoder.
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_tick_gen.sv
// Scan-rate prescaler: pulses tick once every DIV running cycles.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

   // Remaining-cycles down-counter: LOAD means zero cycles elapsed, 0 is terminal count.
   logic [CW-1:0] rem_q, rem_d, rem_eff;

   always_comb begin
      rem_eff = clr ? LOAD : rem_q;
      tick    = run && (rem_eff == '0);
      rem_d   = rem_q;
      if (run) begin
         rem_d = tick ? LOAD : (rem_eff - CW'(1));
      end else if (clr) begin
         rem_d = LOAD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= LOAD;
      end else begin
         rem_q <= rem_d;
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable, output polarity and auto-scan.
//   state     | meaning
//   ST_IDLE   | disabled: outputs inactive, index and prescaler frozen
//   ST_DIRECT | decode external select, prescaler cleared
//   ST_SCAN   | advance index every DIV cycles, pulse step on advance
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter int DIV        = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        in,
   output logic [(1<<SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        index,
   output logic                    step
);

   localparam int NOUT = 1 << SEL_W;
   localparam logic [NOUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  index_q, index_d;
   logic [NOUT-1:0]   out_q, out_d;
   logic              step_q, step_d;
   logic              pre_clr, pre_run, tick;

   // Actions follow the state chosen by the inputs sampled on this edge.
   always_comb begin
      if (!enable) begin
         state_d = ST_IDLE;
      end else if (mode == MODE_DIRECT) begin
         state_d = ST_DIRECT;
      end else begin
         state_d = ST_SCAN;
      end
   end

   assign pre_run = (state_d == ST_SCAN);
   assign pre_clr = (state_d == ST_DIRECT) || ((state_d == ST_SCAN) && (state_q != ST_SCAN));

   tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pre_clr),
      .run   (pre_run),
      .tick  (tick)
   );

   always_comb begin
      index_d = index_q;
      step_d  = 1'b0;
      out_d   = INACTIVE;
      case (state_d)
         ST_DIRECT: index_d = in;
         ST_SCAN: begin
            if (tick) begin
               index_d = index_q + SEL_W'(1);
               step_d  = 1'b1;
            end
         end
         default: ;
      endcase
      if (state_d != ST_IDLE) begin
         out_d = INACTIVE ^ (NOUT'(1) << index_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         index_q <= '0;
         out_q   <= INACTIVE;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         out_q   <= out_d;
         step_q  <= step_d;
      end
   end

   assign out   = out_q;
   assign index = index_q;
   assign step  = step_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: default build plus an 8-output, DIV=1, active-low build.
module tb_decoder_scan;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_a, mode_a;
   logic [1:0] in_a;
   logic [3:0] out_a;
   logic [1:0] idx_a;
   logic       stp_a;
   logic       en_b, mode_b;
   logic [2:0] in_b;
   logic [7:0] out_b;
   logic [2:0] idx_b;
   logic       stp_b;

   int n_cmp = 0;
   int n_bad = 0;

   int m_idx_a, m_age_a, m_out_a;
   bit m_stp_a;
   int m_idx_b, m_age_b, m_out_b;
   bit m_stp_b;

   always #5 clk = ~clk;

   decoder_scan u_dut_a (
      .clk(clk), .rst_n(rst_n), .enable(en_a), .mode(mode_a),
      .in(in_a), .out(out_a), .index(idx_a), .step(stp_a)
   );

   decoder_scan #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .enable(en_b), .mode(mode_b),
      .in(in_b), .out(out_b), .index(idx_b), .step(stp_b)
   );

   // Reference: age counts consecutive scan edges since entry; every DIV-th one is a step.
   task automatic ref_step(input bit en, input bit md, input int sel, input int selw,
                           input int div, input bit al, inout int idx, inout int age,
                           output int outv, output bit stp);
      int n;
      n   = 1 << selw;
      stp = 1'b0;
      if (!en) begin
         age  = 0;
         outv = 0;
      end else if (!md) begin
         age  = 0;
         idx  = sel;
         outv = 1 << idx;
      end else begin
         age = age + 1;
         if (age % div == 0) begin
            stp = 1'b1;
            idx = (idx + 1) % n;
         end
         outv = 1 << idx;
      end
      if (al) outv = ((1 << n) - 1) ^ outv;
   endtask

   task automatic model_reset();
      m_idx_a = 0; m_age_a = 0; m_out_a = 0;    m_stp_a = 1'b0;
      m_idx_b = 0; m_age_b = 0; m_out_b = 8'hFF; m_stp_b = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      ref_step(en_a, mode_a, int'(in_a), 2, 4, 1'b0, m_idx_a, m_age_a, m_out_a, m_stp_a);
      ref_step(en_b, mode_b, int'(in_b), 3, 1, 1'b1, m_idx_b, m_age_b, m_out_b, m_stp_b);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en_a = 1'b0; mode_a = 1'b0; in_a = '0;
      en_b = 1'b0; mode_b = 1'b0; in_b = '0;
      model_reset();
      #12;
      n_cmp++; if (out_a !== 4'b0000) begin n_bad++; $display("FAIL reset_out_a got %h want 0", out_a); end
      n_cmp++; if (idx_a !== 2'd0)    begin n_bad++; $display("FAIL reset_idx_a got %0d want 0", idx_a); end
      n_cmp++; if (stp_a !== 1'b0)    begin n_bad++; $display("FAIL reset_step_a got %b want 0", stp_a); end
      n_cmp++; if (out_b !== 8'hFF)   begin n_bad++; $display("FAIL reset_out_b got %h want ff", out_b); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_direct();
      en_a = 1'b1; mode_a = 1'b0;
      for (int s = 0; s < 4; s++) begin
         in_a = 2'(s);
         tick();
         n_cmp++; if (out_a !== 4'(1 << s)) begin n_bad++; $display("FAIL direct_out in=%0d got %b want %b", s, out_a, 4'(1 << s)); end
         n_cmp++; if (idx_a !== 2'(s))      begin n_bad++; $display("FAIL direct_idx in=%0d got %0d want %0d", s, idx_a, s); end
      end
   endtask

   task automatic test_enable();
      in_a = 2'd3; tick();
      en_a = 1'b0; tick();
      n_cmp++; if (out_a !== 4'b0000) begin n_bad++; $display("FAIL enable_off_out got %b want 0000", out_a); end
      n_cmp++; if (idx_a !== 2'd3)    begin n_bad++; $display("FAIL enable_off_idx got %0d want 3", idx_a); end
      en_a = 1'b1; tick();
      n_cmp++; if (out_a !== 4'b1000) begin n_bad++; $display("FAIL enable_on_out got %b want 1000", out_a); end
   endtask

   task automatic test_scan_wrap();
      int steps;
      logic [3:0] want;
      steps = 0;
      mode_a = 1'b0; in_a = 2'd2; tick();
      mode_a = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (stp_a === 1'b1) steps++;
         n_cmp++; if (out_a !== 4'(m_out_a)) begin n_bad++; $display("FAIL scan_out c=%0d got %b want %b", c, out_a, 4'(m_out_a)); end
         n_cmp++; if (stp_a !== (c % 4 == 0)) begin n_bad++; $display("FAIL scan_step c=%0d got %b want %b", c, stp_a, (c % 4 == 0)); end
         if (c % 4 == 0) begin
            want = (c == 4) ? 4'b1000 : (c == 8) ? 4'b0001 : 4'b0010;
            n_cmp++; if (out_a !== want) begin n_bad++; $display("FAIL scan_wrap c=%0d got %b want %b", c, out_a, want); end
         end
      end
      n_cmp++; if (steps !== 3) begin n_bad++; $display("FAIL scan_step_count got %0d want 3", steps); end
   endtask

   task automatic test_conflicts();
      int guard;
      int held;
      guard = 0;
      while (m_age_a % 4 != 3 && guard < 8) begin tick(); guard++; end
      n_cmp++; if (m_age_a % 4 != 3) begin n_bad++; $display("FAIL conflict_align got age %0d want 3", m_age_a % 4); end
      mode_a = 1'b0; in_a = 2'd1; tick();
      n_cmp++; if (out_a !== 4'b0010) begin n_bad++; $display("FAIL mode_conflict_out got %b want 0010", out_a); end
      n_cmp++; if (stp_a !== 1'b0)    begin n_bad++; $display("FAIL mode_conflict_step got %b want 0", stp_a); end
      mode_a = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      held = m_idx_a;
      en_a = 1'b0; tick();
      n_cmp++; if (out_a !== 4'b0000)  begin n_bad++; $display("FAIL en_conflict_out got %b want 0000", out_a); end
      n_cmp++; if (stp_a !== 1'b0)     begin n_bad++; $display("FAIL en_conflict_step got %b want 0", stp_a); end
      n_cmp++; if (idx_a !== 2'(held)) begin n_bad++; $display("FAIL en_conflict_idx got %0d want %0d", idx_a, held); end
   endtask

   task automatic test_async_reset();
      int guard;
      guard = 0;
      en_a = 1'b1; mode_a = 1'b1;
      tick();
      while (m_idx_a != 3 && guard < 40) begin tick(); guard++; end
      n_cmp++; if (idx_a !== 2'd3) begin n_bad++; $display("FAIL areset_setup_idx got %0d want 3", idx_a); end
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (out_a !== 4'b0000) begin n_bad++; $display("FAIL areset_out got %b want 0000", out_a); end
      n_cmp++; if (idx_a !== 2'd0)    begin n_bad++; $display("FAIL areset_idx got %0d want 0", idx_a); end
      n_cmp++; if (stp_a !== 1'b0)    begin n_bad++; $display("FAIL areset_step got %b want 0", stp_a); end
      #1 rst_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         n_cmp++; if (stp_a !== (c == 4)) begin n_bad++; $display("FAIL areset_restep c=%0d got %b want %b", c, stp_a, (c == 4)); end
         n_cmp++; if (idx_a !== ((c == 4) ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL areset_reidx c=%0d got %0d", c, idx_a); end
      end
   endtask

   task automatic test_corner();
      logic [7:0] seq [9];
      seq = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE, 8'hFD};
      en_b = 1'b1; mode_b = 1'b0; in_b = 3'd0; tick();
      n_cmp++; if (out_b !== 8'hFE) begin n_bad++; $display("FAIL corner_direct got %h want fe", out_b); end
      mode_b = 1'b1;
      for (int c = 0; c < 9; c++) begin
         tick();
         n_cmp++; if (out_b !== seq[c]) begin n_bad++; $display("FAIL corner_out c=%0d got %h want %h", c, out_b, seq[c]); end
         n_cmp++; if (stp_b !== 1'b1)   begin n_bad++; $display("FAIL corner_step c=%0d got %b want 1", c, stp_b); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         en_a = ($urandom_range(0, 7) != 0); mode_a = ($urandom_range(0, 3) != 0); in_a = 2'($urandom);
         en_b = ($urandom_range(0, 7) != 0); mode_b = ($urandom_range(0, 3) != 0); in_b = 3'($urandom);
         tick();
         n_cmp++; if (out_a !== 4'(m_out_a)) begin n_bad++; $display("FAIL rand_out_a c=%0d got %h want %h", c, out_a, 4'(m_out_a)); end
         n_cmp++; if (idx_a !== 2'(m_idx_a)) begin n_bad++; $display("FAIL rand_idx_a c=%0d got %0d want %0d", c, idx_a, m_idx_a); end
         n_cmp++; if (stp_a !== m_stp_a)     begin n_bad++; $display("FAIL rand_step_a c=%0d got %b want %b", c, stp_a, m_stp_a); end
         n_cmp++; if (out_b !== 8'(m_out_b)) begin n_bad++; $display("FAIL rand_out_b c=%0d got %h want %h", c, out_b, 8'(m_out_b)); end
         n_cmp++; if (idx_b !== 3'(m_idx_b)) begin n_bad++; $display("FAIL rand_idx_b c=%0d got %0d want %0d", c, idx_b, m_idx_b); end
         n_cmp++; if (stp_b !== m_stp_b)     begin n_bad++; $display("FAIL rand_step_b c=%0d got %b want %b", c, stp_b, m_stp_b); end
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_enable();
      test_scan_wrap();
      test_conflicts();
      test_async_reset();
      test_corner();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
